// File: rtl/obstacle_scroll_draw_pkg.sv
// Shared types and constants for the scrolling obstacle renderer.
// Includes the height-to-colour helper used when HEIGHT_COLOUR_EN is defined.
package obstacle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAW  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned X_W = $clog2(SCREEN_W);
    localparam int unsigned Y_W = $clog2(SCREEN_H);
    localparam int unsigned C_W = 3;
    localparam int unsigned H_W = 8;

    localparam logic [C_W-1:0] FG_COLOUR_DEF = 3'b010;
    localparam logic [C_W-1:0] BG_COLOUR_DEF = 3'b000;
    localparam logic [C_W-1:0] COLOUR_LOW    = 3'b100;
    localparam logic [C_W-1:0] COLOUR_MID    = 3'b110;
    localparam logic [C_W-1:0] COLOUR_HIGH   = 3'b010;

    localparam int unsigned BAND_LO = 40;
    localparam int unsigned BAND_HI = 80;

    // One registered pixel-plot beat towards the VGA adapter
    typedef struct packed {
        logic           plot;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

    function automatic logic [C_W-1:0] height_colour(input logic [H_W-1:0] h);
        logic [C_W-1:0] c;
        if (h < H_W'(BAND_LO)) begin
            c = COLOUR_LOW;
        end else if (h < H_W'(BAND_HI)) begin
            c = COLOUR_MID;
        end else begin
            c = COLOUR_HIGH;
        end
        return c;
    endfunction

endpackage

// File: rtl/obstacle_scroll_draw_if.sv
// Height-stream input and VGA plot-port output bundle of the obstacle renderer.
// master = upstream/adapter side, slave = the renderer itself.
interface obstacle_scroll_draw_if;

    logic       frame_tick;
    logic [7:0] y_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic       overrun;

    modport master (
        output frame_tick, y_in,
        input  vga_x, vga_y, colour, plot, busy, done, overrun
    );

    modport slave (
        input  frame_tick, y_in,
        output vga_x, vga_y, colour, plot, busy, done, overrun
    );

endinterface

// File: rtl/obstacle_scroll_draw_walker.sv
// Row-major col/dy/dx pixel counter shared by the ERASE and DRAW passes.
// *_c outputs are the counter values for the next cycle; last_c flags the final pixel.
module block_pixel_walker #(
    parameter int unsigned NUM_COLS = 8,
    parameter int unsigned BLK_W    = 4,
    parameter int unsigned BLK_H    = 4,
    parameter int unsigned COL_W    = 3,
    parameter int unsigned DX_W     = 2,
    parameter int unsigned DY_W     = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             step_i,
    output logic [COL_W-1:0] col_c,
    output logic [DX_W-1:0]  dx_c,
    output logic [DY_W-1:0]  dy_c,
    output logic             last_c
);

    logic [COL_W-1:0] col_q, col_d;
    logic [DX_W-1:0]  dx_q,  dx_d;
    logic [DY_W-1:0]  dy_q,  dy_d;

    logic dx_wrap, dy_wrap, col_wrap;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else begin
            col_q <= col_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
        end
    end

    // dx fastest, then dy, then col; the final pixel wraps everything back to 0
    always_comb begin
        dx_wrap  = (dx_q  == DX_W'(BLK_W - 1));
        dy_wrap  = (dy_q  == DY_W'(BLK_H - 1));
        col_wrap = (col_q == COL_W'(NUM_COLS - 1));
        col_d    = col_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        if (start_i) begin
            col_d = '0;
            dx_d  = '0;
            dy_d  = '0;
        end else if (step_i) begin
            if (!dx_wrap) begin
                dx_d = dx_q + DX_W'(1);
            end else begin
                dx_d = '0;
                if (!dy_wrap) begin
                    dy_d = dy_q + DY_W'(1);
                end else begin
                    dy_d  = '0;
                    col_d = col_wrap ? '0 : col_q + COL_W'(1);
                end
            end
        end
    end

    assign col_c  = col_d;
    assign dx_c   = dx_d;
    assign dy_c   = dy_d;
    assign last_c = dx_wrap && dy_wrap && col_wrap;

endmodule

// File: rtl/obstacle_scroll_draw.sv
// Scrolling obstacle renderer: per frame tick erases the old blocks, shifts in a new
// height and redraws. Optional macro HEIGHT_COLOUR_EN colours blocks by height band.
module obstacle_scroll_draw
    import obstacle_pkg::*;
#(
    parameter int unsigned    NUM_COLS  = 8,
    parameter int unsigned    COL_PITCH = 20,
    parameter int unsigned    BLK_W     = 4,
    parameter int unsigned    BLK_H     = 4,
    parameter int unsigned    Y_MAX     = SCREEN_H - 1,
    parameter logic [C_W-1:0] FG_COLOUR = FG_COLOUR_DEF,
    parameter logic [C_W-1:0] BG_COLOUR = BG_COLOUR_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    obstacle_scroll_draw_if.slave  bus
);

    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned DX_W  = (BLK_W > 1)    ? $clog2(BLK_W)    : 1;
    localparam int unsigned DY_W  = (BLK_H > 1)    ? $clog2(BLK_H)    : 1;
    localparam int unsigned H_MAX = Y_MAX - BLK_H + 1;

    state_e state_q, state_d;

    logic [H_W-1:0] h_q [NUM_COLS];
    logic [H_W-1:0] h_d [NUM_COLS];
    logic [H_W-1:0] pend_q, pend_d;
    logic           overrun_q, overrun_d;

    pixel_t         pix_q, pix_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [COL_W-1:0] col_c;
    logic [DX_W-1:0]  dx_c;
    logic [DY_W-1:0]  dy_c;
    logic             last_c;
    logic             walk_start;
    logic             walk_step;
    logic [H_W-1:0]   h_sel;
    logic [C_W-1:0]   draw_colour;

    assign walk_start = (state_q == ST_IDLE);
    assign walk_step  = (state_q == ST_ERASE) || (state_q == ST_DRAW);

    block_pixel_walker #(
        .NUM_COLS (NUM_COLS),
        .BLK_W    (BLK_W),
        .BLK_H    (BLK_H),
        .COL_W    (COL_W),
        .DX_W     (DX_W),
        .DY_W     (DY_W)
    ) u_walker (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (walk_start),
        .step_i  (walk_step),
        .col_c   (col_c),
        .dx_c    (dx_c),
        .dy_c    (dy_c),
        .last_c  (last_c)
    );

    // State, column heights and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            h_q       <= '{default: '0};
            pend_q    <= '0;
            overrun_q <= 1'b0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state, height shift register, pending sample and overrun flag
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick) begin
                    pend_d  = (bus.y_in > H_W'(H_MAX)) ? H_W'(H_MAX) : bus.y_in;
                    state_d = ST_ERASE;
                end
            end
            ST_ERASE: begin
                if (last_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < int'(NUM_COLS) - 1; i++) begin
                    h_d[i] = h_q[i+1];
                end
                h_d[NUM_COLS-1] = pend_q;
                state_d         = ST_DRAW;
            end
            ST_DRAW: begin
                if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (bus.frame_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Output beat for the upcoming cycle, from next state, next counters and next heights
    always_comb begin
        pix_d  = '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        h_sel  = h_d[col_c];
`ifdef HEIGHT_COLOUR_EN
        draw_colour = height_colour(h_sel);
`else
        draw_colour = FG_COLOUR;
`endif
        if ((state_d == ST_ERASE) || (state_d == ST_DRAW)) begin
            pix_d.plot   = 1'b1;
            pix_d.x      = X_W'(32'(col_c) * COL_PITCH + 32'(dx_c));
            pix_d.y      = Y_W'(h_sel) + Y_W'(dy_c);
            pix_d.colour = (state_d == ST_ERASE) ? BG_COLOUR : draw_colour;
        end
    end

    assign bus.vga_x   = pix_q.x;
    assign bus.vga_y   = pix_q.y;
    assign bus.colour  = pix_q.colour;
    assign bus.plot    = pix_q.plot;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_obstacle_scroll_draw.sv
// Directed bench for obstacle_scroll_draw: captures each frame cycle by cycle and
// compares against a small height-window model plus hand-computed spot values.
module tb_obstacle_scroll_draw;

    localparam int FRAME_LEN = 260;
    localparam int NPIX      = 128;

    logic clk;
    logic resetn;

    obstacle_scroll_draw_if bus();

    obstacle_scroll_draw dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int first_bad;

    logic [7:0] exp_h   [8];
    logic [7:0] exp_old [8];

    logic       cap_plot    [0:FRAME_LEN];
    logic [7:0] cap_x       [0:FRAME_LEN];
    logic [6:0] cap_y       [0:FRAME_LEN];
    logic [2:0] cap_col     [0:FRAME_LEN];
    logic       cap_busy    [0:FRAME_LEN];
    logic       cap_done    [0:FRAME_LEN];
    logic       cap_overrun [0:FRAME_LEN];

    function automatic logic [2:0] exp_draw_col(input logic [7:0] h);
`ifdef HEIGHT_COLOUR_EN
        if (h < 8'd40) return 3'b100;
        if (h < 8'd80) return 3'b110;
        return 3'b010;
`else
        return 3'b010;
`endif
    endfunction

    // Number of captured cycles that disagree with the expected frame; first one in first_bad
    function automatic int frame_bad();
        int bad = 0;
        first_bad = -1;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            logic       ep, eb, ed;
            logic [7:0] ex;
            logic [6:0] ey;
            logic [2:0] ec;
            int         p, col, dx, dy;
            ep = 1'b0; ex = 8'd0; ey = 7'd0; ec = 3'd0;
            eb = (k <= 258);
            ed = (k == 258);
            if (k <= NPIX) begin
                p = k - 1; col = p / 16; dy = (p % 16) / 4; dx = p % 4;
                ep = 1'b1;
                ex = 8'(col * 20 + dx);
                ey = 7'(int'(exp_old[col]) + dy);
                ec = 3'b000;
            end else if (k >= 130 && k <= 257) begin
                p = k - 130; col = p / 16; dy = (p % 16) / 4; dx = p % 4;
                ep = 1'b1;
                ex = 8'(col * 20 + dx);
                ey = 7'(int'(exp_h[col]) + dy);
                ec = exp_draw_col(exp_h[col]);
            end
            if (cap_plot[k] !== ep || cap_busy[k] !== eb || cap_done[k] !== ed ||
                (ep && (cap_x[k] !== ex || cap_y[k] !== ey || cap_col[k] !== ec))) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        return bad;
    endfunction

    // One tick with height y, optional extra tick at cycle 'inject' of the frame
    task automatic run_frame(input logic [7:0] y, input int inject);
        exp_old = exp_h;
        for (int i = 0; i < 7; i++) exp_h[i] = exp_old[i+1];
        exp_h[7] = (y > 8'd116) ? 8'd116 : y;
        bus.y_in       = y;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        for (int k = 1; k <= FRAME_LEN; k++) begin
            cap_plot[k]    = bus.plot;
            cap_x[k]       = bus.vga_x;
            cap_y[k]       = bus.vga_y;
            cap_col[k]     = bus.colour;
            cap_busy[k]    = bus.busy;
            cap_done[k]    = bus.done;
            cap_overrun[k] = bus.overrun;
            if (k == inject) begin
                bus.frame_tick = 1'b1;
                bus.y_in       = 8'd99;
            end
            @(posedge clk); #1;
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++; if (bus.plot !== 1'b0)    begin errors++; $display("FAIL reset_plot got=%b exp=0", bus.plot); end
        checks++; if (bus.vga_x !== 8'd0)   begin errors++; $display("FAIL reset_x got=%0d exp=0", bus.vga_x); end
        checks++; if (bus.vga_y !== 7'd0)   begin errors++; $display("FAIL reset_y got=%0d exp=0", bus.vga_y); end
        checks++; if (bus.colour !== 3'd0)  begin errors++; $display("FAIL reset_colour got=%b exp=000", bus.colour); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    endtask

    task automatic test_first_frame();
        int bad;
        run_frame(8'd50, 0);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL frame50_pixels bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_plot[1] !== 1'b1 || cap_x[1] !== 8'd0 || cap_y[1] !== 7'd0)
            begin errors++; $display("FAIL first_plot plot=%b x=%0d y=%0d exp 1/0/0", cap_plot[1], cap_x[1], cap_y[1]); end
        checks++; if (cap_x[128] !== 8'd143 || cap_y[128] !== 7'd3)
            begin errors++; $display("FAIL erase_last x=%0d y=%0d exp 143/3", cap_x[128], cap_y[128]); end
        checks++; if (cap_plot[129] !== 1'b0) begin errors++; $display("FAIL shift_plot got=%b exp=0", cap_plot[129]); end
        checks++; if (cap_x[242] !== 8'd140 || cap_y[242] !== 7'd50)
            begin errors++; $display("FAIL col7_draw_first x=%0d y=%0d exp 140/50", cap_x[242], cap_y[242]); end
        checks++; if (cap_x[257] !== 8'd143 || cap_y[257] !== 7'd53)
            begin errors++; $display("FAIL col7_draw_last x=%0d y=%0d exp 143/53", cap_x[257], cap_y[257]); end
        checks++; if (cap_done[257] !== 1'b0 || cap_done[258] !== 1'b1 || cap_done[259] !== 1'b0)
            begin errors++; $display("FAIL done_timing d257=%b d258=%b d259=%b exp 0/1/0", cap_done[257], cap_done[258], cap_done[259]); end
    endtask

    task automatic test_clamp();
        int bad;
        run_frame(8'd200, 0);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_pixels bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_x[242] !== 8'd140 || cap_y[242] !== 7'd116)
            begin errors++; $display("FAIL clamp_top x=%0d y=%0d exp 140/116", cap_x[242], cap_y[242]); end
        checks++; if (cap_x[257] !== 8'd143 || cap_y[257] !== 7'd119)
            begin errors++; $display("FAIL clamp_last x=%0d y=%0d exp 143/119", cap_x[257], cap_y[257]); end
    endtask

    task automatic test_eight_frames();
        int bad = 0;
        for (int f = 1; f <= 8; f++) begin
            run_frame(8'(f * 10), 0);
            bad += frame_bad();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL eight_frames_pixels bad=%0d exp=0", bad); end
        run_frame(8'd0, 0);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL ninth_frame_pixels bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_x[1] !== 8'd0 || cap_y[1] !== 7'd10)
            begin errors++; $display("FAIL ninth_erase_col0 x=%0d y=%0d exp 0/10", cap_x[1], cap_y[1]); end
        checks++; if (cap_x[128] !== 8'd143 || cap_y[128] !== 7'd83)
            begin errors++; $display("FAIL ninth_erase_col7 x=%0d y=%0d exp 143/83", cap_x[128], cap_y[128]); end
    endtask

    task automatic test_overrun();
        int bad;
        run_frame(8'd33, 5);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL overrun_frame bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_overrun[5] !== 1'b0 || cap_overrun[6] !== 1'b1)
            begin errors++; $display("FAIL overrun_set o5=%b o6=%b exp 0/1", cap_overrun[5], cap_overrun[6]); end
        run_frame(8'd44, 0);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL no_extra_shift bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", bus.overrun); end
    endtask

    task automatic test_reset_mid_draw();
        int bad;
        bus.y_in       = 8'd5;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        repeat (140) @(posedge clk);
        #1;
        checks++; if (bus.plot !== 1'b1) begin errors++; $display("FAIL mid_draw_plot got=%b exp=1", bus.plot); end
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0)
            begin errors++; $display("FAIL reset_abort plot=%b busy=%b overrun=%b exp 0/0/0", bus.plot, bus.busy, bus.overrun); end
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) exp_h[i] = 8'd0;
        @(posedge clk); #1;
        run_frame(8'd7, 258);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_frame bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_y[1] !== 7'd0 || cap_y[128] !== 7'd3)
            begin errors++; $display("FAIL post_reset_erase y1=%0d y128=%0d exp 0/3", cap_y[1], cap_y[128]); end
        checks++; if (cap_overrun[258] !== 1'b0 || cap_overrun[259] !== 1'b1)
            begin errors++; $display("FAIL done_tick_overrun o258=%b o259=%b exp 0/1", cap_overrun[258], cap_overrun[259]); end
    endtask

    task automatic test_height_colour();
        int bad;
        logic [2:0] e30, e60, e100;
`ifdef HEIGHT_COLOUR_EN
        e30 = 3'b100; e60 = 3'b110; e100 = 3'b010;
`else
        e30 = 3'b010; e60 = 3'b010; e100 = 3'b010;
`endif
        run_frame(8'd30, 0);
        run_frame(8'd60, 0);
        run_frame(8'd100, 0);
        bad = frame_bad();
        checks++; if (bad !== 0) begin errors++; $display("FAIL colour_frame bad=%0d first_cycle=%0d exp bad=0", bad, first_bad); end
        checks++; if (cap_col[210] !== e30)  begin errors++; $display("FAIL colour_h30 got=%b exp=%b", cap_col[210], e30); end
        checks++; if (cap_col[226] !== e60)  begin errors++; $display("FAIL colour_h60 got=%b exp=%b", cap_col[226], e60); end
        checks++; if (cap_col[242] !== e100) begin errors++; $display("FAIL colour_h100 got=%b exp=%b", cap_col[242], e100); end
    endtask

    initial begin
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.y_in       = 8'd0;
        for (int i = 0; i < 8; i++) exp_h[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        @(posedge clk); #1;
        test_first_frame();
        test_clamp();
        test_eight_frames();
        test_overrun();
        test_reset_mid_draw();
        test_height_colour();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/obstacle_scroll_draw.md
Name: obstacle_scroll_draw

Overview:
- Downstream consumer of the double-buffered height stream, which delivers one 8-bit height sample per frame slot.
- Keeps a scrolling window of NUM_COLS obstacle heights and renders them as solid blocks into the VGA adapter pixel-plot interface.
- Each frame tick runs three phases: erase the previous blocks, shift in the new sample, then draw the new blocks.
- Sits between the height buffer and the vga_adapter plot port.

Parameters:
- NUM_COLS, 8, number of on-screen obstacle columns.
- COL_PITCH, 20, x distance in pixels between adjacent columns.
- BLK_W, 4, block width in pixels.
- BLK_H, 4, block height in pixels.
- Y_MAX, 119, last visible screen row.
- FG_COLOUR, 3'b010, block colour.
- BG_COLOUR, 3'b000, erase colour.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset: synchronous, active-low.
- frame_tick  in  1  one-cycle pulse requesting a scroll/redraw.
- y_in  in  8  new obstacle height from the buffer stage; sampled on an accepted tick.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high from the first ERASE cycle through DONE.
- done  out  1  one-cycle pulse when the frame is finished.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset:
  - All outputs are 0: vga_x, vga_y, colour, plot, busy, done, overrun.
  - All stored column heights are 0.
  - State goes to IDLE.
  - Reset mid-frame abandons drawing immediately. The screen is not cleaned up.
- States: IDLE, ERASE, SHIFT, DRAW, DONE.
- IDLE, tick arrives:
  - frame_tick=1 registers clamp(y_in) into pend_h, then state goes to ERASE.
  - Clamp rule: h = min(y_in, Y_MAX-BLK_H+1). With defaults the maximum is 116.
- ERASE:
  - Walks col 0..NUM_COLS-1. Within each block, dy is the outer loop and dx the inner (row-major).
  - One pixel per cycle, with plot=1 and colour=BG_COLOUR.
  - Pixel address: vga_x = col*COL_PITCH + dx, vga_y = h[col] + dy.
  - Length: NUM_COLS*BLK_W*BLK_H cycles (128 with defaults).
- SHIFT:
  - Lasts 1 cycle with plot=0.
  - h[i] <= h[i+1] for i < NUM_COLS-1, and h[NUM_COLS-1] <= pend_h, so obstacles scroll left.
- DRAW:
  - Same walk as ERASE, using the new heights and colour=FG_COLOUR. Length is 128 cycles.
- DONE:
  - Lasts 1 cycle with done=1 and plot=0, then returns to IDLE.
- Latency:
  - The first plot occurs in the cycle after the accepting tick.
  - done arrives 2*N+2 cycles after the tick, where N = NUM_COLS*BLK_W*BLK_H (258 with defaults).
- Ticks while busy:
  - frame_tick in any state other than IDLE is ignored, and y_in is not sampled.
  - overrun is set and stays set until reset.
  - A tick in the DONE cycle also counts as an overrun.
- Outputs are registered. plot, vga_x, vga_y and colour are mutually consistent in the same cycle.
- Address arithmetic:
  - Widths: col counter is clog2(NUM_COLS) bits, dx/dy counters are clog2(BLK_W)/clog2(BLK_H) bits.
  - x sum is 8 bits; the maximum with defaults is 7*20+3 = 143.
  - y sum is 7 bits and cannot exceed Y_MAX because of the clamp.
- Counter wrap: dx wraps to 0 and increments dy. dy wrap increments col. col wrap ends the phase.

Optional Feature:
- Macro: HEIGHT_COLOUR_EN.
- Defined: DRAW colour is derived from the block height:
  - h < 40 gives 3'b100.
  - 40 <= h < 80 gives 3'b110.
  - h >= 80 gives 3'b010.
  - ERASE still uses BG_COLOUR.
- Undefined: DRAW always uses FG_COLOUR.
- Ports and timing are identical in both cases.

Decomposition:
- Shared package obstacle_pkg holds:
  - state enum;
  - SCREEN_W=160 and SCREEN_H=120;
  - default colour constants;
  - height-band thresholds 40/80.
- One natural sub-module: block_pixel_walker. It holds the col/dx/dy counters with start/last outputs and is reused for both ERASE and DRAW.

Test Plan:
- Reset, then one tick with y_in=50:
  - 128 BG plots at y 0..3, then 128 FG plots.
  - Column 7 is drawn at x 140..143, y 50..53; columns 0..6 are drawn at y 0..3.
  - done pulses at tick+258.
- y_in=200:
  - The stored height is clamped to 116.
  - The last DRAW pixel is x=143, y=119.
- Eight ticks with y_in=10,20,...,80:
  - After the 8th frame, column 0 is at height 10 and column 7 at height 80.
  - The ERASE of the 9th frame covers exactly those rectangles.
- Tick at cycle 5 of a frame:
  - overrun=1 and the frame completes unchanged.
  - Heights show no extra shift and overrun stays 1.
- resetn=0 during DRAW:
  - Next cycle plot=0, busy=0 and all heights are 0.
  - A subsequent tick erases at y 0..3.
- With HEIGHT_COLOUR_EN defined, heights 30, 60 and 100 draw in colours 100, 110 and 010.
